// File: rtl/stack_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stack_sequencer: byte-serial push/pop engine for a page-0x01 stack.  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module stack_sequencer (
  input  logic        clk_1,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic        cmd_push,
  input  logic [1:0]  cmd_len,
  output logic        cmd_ready,
  input  logic [23:0] push_data,
  input  logic [7:0]  sp_in,
  output logic [7:0]  sp_out,
  output logic        sp_we,
  output logic [23:0] pop_data,
  output logic        pop_valid,
  output logic        sp_wrap,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  sp_q, sp_d;
  logic [1:0]  rem_q, rem_d;
  logic [1:0]  idx_q, idx_d;
  logic        push_q, push_d;
  logic [23:0] wdata_q, wdata_d;
  logic [23:0] buf_q, buf_d;
  logic [23:0] pop_data_q, pop_data_d;
  logic        wrap_q, wrap_d;
  logic [7:0]  sp_out_q, sp_out_d;
  logic [7:0]  sp_inc, sp_dec;

  assign sp_inc = sp_q + 8'd1;
  assign sp_dec = sp_q - 8'd1;

  always_ff @(posedge clk_1) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sp_q       <= 8'h00;
      rem_q      <= 2'd0;
      idx_q      <= 2'd0;
      push_q     <= 1'b0;
      wdata_q    <= 24'h0;
      buf_q      <= 24'h0;
      pop_data_q <= 24'h0;
      wrap_q     <= 1'b0;
      sp_out_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      push_q     <= push_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      pop_data_q <= pop_data_d;
      wrap_q     <= wrap_d;
      sp_out_q   <= sp_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    push_d     = push_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    pop_data_d = pop_data_q;
    wrap_d     = wrap_q;
    sp_out_d   = sp_out_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && (cmd_len != 2'd0)) begin
          state_d = S_XFER;
          sp_d    = sp_in;
          rem_d   = cmd_len;
          idx_d   = 2'd0;
          push_d  = cmd_push;
          wdata_d = push_data;
          buf_d   = 24'h0;
          wrap_d  = 1'b0;
        end
      end
      S_XFER: begin
        if (mem_ack) begin
          // Push data shifts down so the current byte always sits in [7:0].
          if (push_q) begin
            sp_d    = sp_dec;
            wdata_d = {8'h00, wdata_q[23:8]};
            if (sp_q == 8'h00) wrap_d = 1'b1;
          end else begin
            sp_d = sp_inc;
            buf_d[{idx_q, 3'b000} +: 8] = mem_rdata;
            if (sp_q == 8'hFF) wrap_d = 1'b1;
          end
          idx_d = idx_q + 2'd1;
          rem_d = rem_q - 2'd1;
          if (rem_q == 2'd1) begin
            state_d  = S_DONE;
            sp_out_d = sp_d;
            if (!push_q) pop_data_d = buf_d;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign mem_req   = (state_q == S_XFER);
  assign mem_we    = mem_req & push_q;
  assign mem_addr  = mem_req ? {8'h01, (push_q ? sp_q : sp_inc)} : 16'h0000;
  assign mem_wdata = mem_we ? wdata_q[7:0] : 8'h00;
  assign sp_we     = (state_q == S_DONE);
  assign sp_out    = sp_out_q;
  assign sp_wrap   = sp_we & wrap_q;
  assign pop_valid = sp_we & ~push_q;
  assign pop_data  = pop_data_q;

endmodule
`default_nettype wire

// File: tb/tb_stack_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_stack_sequencer: directed self-checking bench for stack_sequencer.|
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_stack_sequencer;

  logic        clk_1 = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_push, cmd_ready;
  logic [1:0]  cmd_len;
  logic [23:0] push_data, pop_data;
  logic [7:0]  sp_in, sp_out;
  logic        sp_we, pop_valid, sp_wrap;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  always #5 clk_1 = ~clk_1;

  stack_sequencer dut (
    .clk_1     (clk_1),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_push  (cmd_push),
    .cmd_len   (cmd_len),
    .cmd_ready (cmd_ready),
    .push_data (push_data),
    .sp_in     (sp_in),
    .sp_out    (sp_out),
    .sp_we     (sp_we),
    .pop_data  (pop_data),
    .pop_valid (pop_valid),
    .sp_wrap   (sp_wrap),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  logic [7:0]  mem [0:65535];
  int          wait_cyc = 0;
  int          wcnt = 0;
  logic [15:0] ack_addr = 16'h0;
  logic        ack_we = 1'b0;
  logic [7:0]  ack_wd = 8'h0;
  logic [15:0] wr_addr [$];
  logic [7:0]  wr_data [$];
  logic [15:0] rd_addr [$];
  int          n_spwe = 0, n_popv = 0, n_req = 0, n_unstable = 0;
  logic        prev_req = 1'b0, prev_we = 1'b0;
  logic [15:0] prev_addr = 16'h0;
  logic [7:0]  prev_wd = 8'h0;
  int          n_chk = 0, n_pass = 0;

  // Memory model: acks after wait_cyc stall cycles, commits on the edge it was sampled.
  always @(negedge clk_1) begin
    if (sp_we)     n_spwe++;
    if (pop_valid) n_popv++;
    if (mem_req)   n_req++;
    if (mem_req && prev_req && !mem_ack &&
        (mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wd))
      n_unstable++;
    prev_req  = mem_req;
    prev_addr = mem_addr;
    prev_we   = mem_we;
    prev_wd   = mem_wdata;
    if (mem_ack) begin
      if (ack_we) begin
        mem[ack_addr] = ack_wd;
        wr_addr.push_back(ack_addr);
        wr_data.push_back(ack_wd);
      end else begin
        rd_addr.push_back(ack_addr);
      end
      wcnt = 0;
    end
    mem_ack = 1'b0;
    if (!mem_req) begin
      wcnt = 0;
    end else if (wcnt >= wait_cyc) begin
      mem_ack   = 1'b1;
      mem_rdata = mem[mem_addr];
      ack_addr  = mem_addr;
      ack_we    = mem_we;
      ack_wd    = mem_wdata;
    end else begin
      wcnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_1);
    #1;
  endtask

  task automatic issue(input logic p, input logic [1:0] len, input logic [23:0] d,
                       input logic [7:0] sp);
    cmd_valid = 1'b1;
    cmd_push  = p;
    cmd_len   = len;
    push_data = d;
    sp_in     = sp;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Returns the cycle index (accept = 0) at which sp_we was seen.
  task automatic run_cmd(input logic p, input logic [1:0] len, input logic [23:0] d,
                         input logic [7:0] sp, output int cyc);
    issue(p, len, d, sp);
    cyc = 1;
    while (sp_we !== 1'b1 && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, req0, spwe0, popv0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_push = 1'b0; cmd_len = 2'd0;
    push_data = 24'h0; sp_in = 8'h0; mem_ack = 1'b0; mem_rdata = 8'h0;
    tick(); tick();
    chk("rst_ready",   {31'd0, cmd_ready}, 32'd1);
    chk("rst_strobes", {27'd0, mem_req, mem_we, sp_we, pop_valid, sp_wrap}, 32'd0);
    chk("rst_addr",    {16'd0, mem_addr}, 32'd0);
    chk("rst_wdata",   {24'd0, mem_wdata}, 32'd0);
    chk("rst_sp_out",  {24'd0, sp_out}, 32'd0);
    chk("rst_pop_data", {8'd0, pop_data}, 32'd0);
    rst = 1'b0;
    tick();

    // 3-byte push, zero wait
    wr_addr.delete(); wr_data.delete();
    run_cmd(1'b1, 2'd3, 24'h302010, 8'hFD, cyc);
    chk("t1_done_cyc", cyc, 32'd4);
    chk("t1_sp_out", {24'd0, sp_out}, 32'h FA);
    chk("t1_wrap_popv", {30'd0, sp_wrap, pop_valid}, 32'd0);
    tick();
    chk("t1_ready", {30'd0, cmd_ready, sp_we}, 32'd2);
    chk("t1_sp_hold", {24'd0, sp_out}, 32'h FA);
    chk("t1_nwr", wr_addr.size(), 32'd3);
    if (wr_addr.size() == 3) begin
      chk("t1_wr0", {8'd0, wr_addr[0], wr_data[0]}, 32'h0001FD10);
      chk("t1_wr1", {8'd0, wr_addr[1], wr_data[1]}, 32'h0001FC20);
      chk("t1_wr2", {8'd0, wr_addr[2], wr_data[2]}, 32'h0001FB30);
    end

    // 2-byte pop, two wait cycles per byte
    mem[16'h01FB] = 8'h34; mem[16'h01FC] = 8'h12;
    wait_cyc = 2; rd_addr.delete();
    run_cmd(1'b0, 2'd2, 24'h0, 8'hFA, cyc);
    chk("t2_done_cyc", cyc, 32'd7);
    chk("t2_pop_valid", {31'd0, pop_valid}, 32'd1);
    chk("t2_pop_data", {8'd0, pop_data}, 32'h001234);
    chk("t2_sp_out", {24'd0, sp_out}, 32'h FC);
    chk("t2_wrap", {31'd0, sp_wrap}, 32'd0);
    tick();
    chk("t2_hold", {7'd0, pop_valid, pop_data}, 32'h001234);
    chk("t2_nrd", rd_addr.size(), 32'd2);
    if (rd_addr.size() == 2)
      chk("t2_rd_addrs", {rd_addr[0], rd_addr[1]}, 32'h01FB01FC);

    // Push wrapping through 0x00
    wait_cyc = 0; wr_addr.delete(); wr_data.delete();
    run_cmd(1'b1, 2'd2, 24'h00BBAA, 8'h00, cyc);
    chk("t3_done_cyc", cyc, 32'd3);
    chk("t3_sp_out", {24'd0, sp_out}, 32'h FE);
    chk("t3_wrap", {31'd0, sp_wrap}, 32'd1);
    tick();
    chk("t3_nwr", wr_addr.size(), 32'd2);
    if (wr_addr.size() == 2) begin
      chk("t3_wr0", {8'd0, wr_addr[0], wr_data[0]}, 32'h000100AA);
      chk("t3_wr1", {8'd0, wr_addr[1], wr_data[1]}, 32'h0001FFBB);
    end

    // Pop wrapping through 0xFF
    run_cmd(1'b0, 2'd1, 24'h0, 8'hFF, cyc);
    chk("t3b_done_cyc", cyc, 32'd2);
    chk("t3b_pop_data", {8'd0, pop_data}, 32'h0000AA);
    chk("t3b_sp_wrap", {23'd0, sp_out, sp_wrap}, 32'h001);
    tick();

    // Zero-length command is ignored
    req0 = n_req; spwe0 = n_spwe;
    cmd_valid = 1'b1; cmd_push = 1'b1; cmd_len = 2'd0; sp_in = 8'h20;
    repeat (3) tick();
    chk("t4_len0_ready", {31'd0, cmd_ready}, 32'd1);
    chk("t4_len0_noreq", n_req - req0, 32'd0);
    chk("t4_len0_nospwe", n_spwe - spwe0, 32'd0);
    chk("t4_len0_sp_out", {24'd0, sp_out}, 32'h00);

    // Command held while busy is accepted when cmd_ready returns
    cmd_push = 1'b1; cmd_len = 2'd1; push_data = 24'h000055; sp_in = 8'h40;
    tick();
    cmd_push = 1'b0; sp_in = 8'h3F;
    chk("t4_busy_c1", {13'd0, cmd_ready, mem_req, mem_we, mem_addr}, 32'h00030140);
    tick();
    chk("t4_busy_done", {22'd0, cmd_ready, sp_we, sp_out}, 32'h13F);
    tick();
    chk("t4_ready_back", {30'd0, cmd_ready, mem_req}, 32'd2);
    tick();
    cmd_valid = 1'b0;
    chk("t4_held_access", {14'd0, mem_req, mem_we, mem_addr}, 32'h00020140);
    tick();
    chk("t4_held_pop", {7'd0, pop_valid, pop_data}, 32'h1000055);
    chk("t4_held_sp", {24'd0, sp_out}, 32'h40);
    tick();

    // Reset on the second byte of a 3-byte pop
    mem[16'h0111] = 8'h77; mem[16'h0112] = 8'h88; mem[16'h0113] = 8'h99;
    spwe0 = n_spwe; popv0 = n_popv;
    issue(1'b0, 2'd3, 24'h0, 8'h10);
    chk("t5_byte0", {16'd0, mem_addr}, 32'h0111);
    tick();
    chk("t5_byte1", {16'd0, mem_addr}, 32'h0112);
    rst = 1'b1;
    tick();
    chk("t5_abort", {30'd0, mem_req, cmd_ready}, 32'd1);
    rst = 1'b0;
    repeat (3) tick();
    chk("t5_no_strobe", (n_spwe - spwe0) + (n_popv - popv0), 32'd0);
    chk("t5_cleared", {sp_out, pop_data}, 32'd0);
    run_cmd(1'b0, 2'd1, 24'h0, 8'h10, cyc);
    chk("t5_after_cyc", cyc, 32'd2);
    chk("t5_after_pop", {7'd0, pop_valid, pop_data}, 32'h1000077);
    chk("t5_after_sp", {24'd0, sp_out}, 32'h11);
    tick();

    chk("mem_stable", n_unstable, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
